cache_fill_arbiter: RTL

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and write-through stores onto one memory port.
// Define CACHE_FILL_ARB_ROUND_ROBIN_EN to alternate d_miss/i_miss ties instead of always favouring D.
module cache_fill_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wr_data,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  // The 3-bit word index and the 16-byte block base both assume eight 16-bit words.
  if (BLOCK_WORDS != 8 || MEM_LATENCY < 1) begin : g_bad_cfg
    $error("cache_fill_arbiter: BLOCK_WORDS must be 8 and MEM_LATENCY at least 1");
  end

  logic [2:0]  state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [11:0] base_q, base_d;
  logic        req_d_q, req_d_d;

  logic gnt_wr, gnt_d, gnt_i;
  logic beat, last_beat;

  // Byte offset within the block is irrelevant once the block base is latched.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

`ifdef CACHE_FILL_ARB_ROUND_ROBIN_EN
  logic last_i_q, last_i_d;

  assign gnt_wr = d_wr;
  assign gnt_d  = !d_wr && d_miss && (!i_miss || last_i_q);
  assign gnt_i  = !d_wr && i_miss && (!d_miss || !last_i_q);
`else
  assign gnt_wr = d_wr;
  assign gnt_d  = !d_wr && d_miss;
  assign gnt_i  = !d_wr && !d_miss && i_miss;
`endif

  assign beat      = mem_data_valid && (state_q == S_ISSUE || state_q == S_DRAIN);
  assign last_beat = beat && (recv_cnt_q == LAST_WORD);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = beat ? recv_cnt_q + 3'd1 : recv_cnt_q;
    base_d      = base_q;
    req_d_d     = req_d_q;
`ifdef CACHE_FILL_ARB_ROUND_ROBIN_EN
    last_i_d    = last_i_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_wr || gnt_d || gnt_i) begin
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
        end
        if (gnt_wr) begin
          state_d = S_WRITE;
        end else if (gnt_d || gnt_i) begin
          state_d = S_ISSUE;
          base_d  = gnt_d ? d_miss_addr[15:4] : i_miss_addr[15:4];
          req_d_d = gnt_d;
`ifdef CACHE_FILL_ARB_ROUND_ROBIN_EN
          last_i_d = gnt_i;
`endif
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 3'd1;
        if (issue_cnt_q == LAST_WORD) begin
          state_d = last_beat ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      base_q      <= 12'd0;
      req_d_q     <= 1'b0;
`ifdef CACHE_FILL_ARB_ROUND_ROBIN_EN
      last_i_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
      req_d_q     <= req_d_d;
`ifdef CACHE_FILL_ARB_ROUND_ROBIN_EN
      last_i_q    <= last_i_d;
`endif
    end
  end

  // Outputs decode from registered state; only the fill strobes follow mem_data_valid directly.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'd0;
    mem_wr_data = 16'd0;
    fill_data   = 16'd0;
    fill_word   = 3'd0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    case (state_q)
      S_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_wr_data = d_wr_data;
        d_wr_ack    = 1'b1;
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {base_q, issue_cnt_q, 1'b0};
      end
      S_DONE: begin
        i_fill_done = !req_d_q;
        d_fill_done = req_d_q;
      end
      default: ;
    endcase
    if (beat) begin
      fill_data = mem_rd_data;
      fill_word = recv_cnt_q;
      i_fill_we = !req_d_q;
      d_fill_we = req_d_q;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
